// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the street-side traffic sensor model.
//   L_RED / L_YEL / L_GRN : one-hot light codes {R,Y,G} driven by the
//                           two-street traffic light controller.
//   is_legal_light(code)  : true when code is exactly one of the three
//                           light codes above.
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  function automatic logic is_legal_light(input logic [2:0] code);
    return (code == L_RED) || (code == L_YEL) || (code == L_GRN);
  endfunction

endpackage

// File: rtl/street_lane.sv
// ---------------------------------------------------------------------------
// street_lane
// Vehicle queue model for one street. Cars arrive on single-cycle pulses and
// leave one at a time, every DRAIN_TICKS cycles, while the light is green.
// A presence filter asserts T once the queue has been non-empty for HOLD
// consecutive edges.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   arr    in   one-cycle car-arrival pulse
//   L      in   light code {R,Y,G}
//   T      out  traffic present (registered decode)
//   q      out  queue occupancy, saturates at 2^QW-1
//   depart out  one-cycle departure pulse
//   ovf    out  sticky overflow flag (arrival into a full queue)
// ---------------------------------------------------------------------------
module street_lane
  import traffic_pkg::*;
#(
  parameter int QW          = 4,
  parameter int DRAIN_TICKS = 6,
  parameter int HOLD        = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr,
  input  logic [2:0]    L,
  output logic          T,
  output logic [QW-1:0] q,
  output logic          depart,
  output logic          ovf
);

  // Widths sized so the terminal values DRAIN_TICKS-1 and HOLD are representable
  // even when a parameter is 1.
  localparam int TW = $clog2(DRAIN_TICKS + 1);
  localparam int PW = $clog2(HOLD + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(DRAIN_TICKS - 1);
  localparam logic [PW-1:0] PRES_FULL  = PW'(HOLD);
  localparam logic [QW-1:0] Q_MAX      = '1;

  logic [QW-1:0] r_q;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_pcount;
  logic          r_depart;
  logic          r_ovf;

  logic w_green;
  logic w_nonempty;
  logic w_fire;

  // Only an exact green code lets cars leave; yellow, red and illegal codes
  // all hold the queue.
  assign w_green    = (L == L_GRN);
  assign w_nonempty = (r_q != '0);
  assign w_fire     = w_green && w_nonempty && (r_timer == TIMER_LAST);

  // Drain timer restarts whenever the light leaves green or the queue empties,
  // so each green phase with waiting cars pays the full DRAIN_TICKS latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (!w_green || !w_nonempty || w_fire) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Arrival and departure on the same edge cancel; an arrival into a full
  // queue is dropped and remembered in the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (arr && !w_fire) begin
      if (r_q == Q_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_q <= r_q + 1'b1;
      end
    end else if (!arr && w_fire) begin
      r_q <= r_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depart <= 1'b0;
    end else begin
      r_depart <= w_fire;
    end
  end

  // Presence filter looks at the queue before the edge, so a fresh arrival
  // needs HOLD further edges before T rises, and T drops one edge after empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcount <= '0;
    end else if (!w_nonempty) begin
      r_pcount <= '0;
    end else if (r_pcount != PRES_FULL) begin
      r_pcount <= r_pcount + 1'b1;
    end
  end

  assign T      = (r_pcount == PRES_FULL);
  assign q      = r_q;
  assign depart = r_depart;
  assign ovf    = r_ovf;

endmodule

// File: rtl/traffic_sensor_model.sv
// ---------------------------------------------------------------------------
// traffic_sensor_model
// Street-side counterpart of the two-street traffic light controller. Turns
// the controller's light codes into traffic-present sensors via two vehicle
// queue models and flags unsafe or illegal light combinations.
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   arrA / arrB     in   one-cycle car-arrival pulses
//   LA / LB         in   light codes {R,Y,G}
//   Ta / Tb         out  traffic present
//   qA / qB         out  queue occupancy
//   departA/departB out  one-cycle departure pulses
//   ovfA / ovfB     out  sticky overflow flags
//   conflict        out  sticky light-safety error
// ---------------------------------------------------------------------------
module traffic_sensor_model
  import traffic_pkg::*;
#(
  parameter int QW          = 4,
  parameter int DRAIN_TICKS = 6,
  parameter int HOLD        = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrA,
  input  logic          arrB,
  input  logic [2:0]    LA,
  input  logic [2:0]    LB,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qA,
  output logic [QW-1:0] qB,
  output logic          departA,
  output logic          departB,
  output logic          ovfA,
  output logic          ovfB,
  output logic          conflict
);

  logic w_unsafe;
  logic r_conflict;

  street_lane #(.QW(QW), .DRAIN_TICKS(DRAIN_TICKS), .HOLD(HOLD)) u_laneA (
    .clk    (clk),
    .reset  (reset),
    .arr    (arrA),
    .L      (LA),
    .T      (Ta),
    .q      (qA),
    .depart (departA),
    .ovf    (ovfA)
  );

  street_lane #(.QW(QW), .DRAIN_TICKS(DRAIN_TICKS), .HOLD(HOLD)) u_laneB (
    .clk    (clk),
    .reset  (reset),
    .arr    (arrB),
    .L      (LB),
    .T      (Tb),
    .q      (qB),
    .depart (departB),
    .ovf    (ovfB)
  );

  // At least one street must show red at all times; any non-one-hot code is
  // also treated as a safety violation.
  assign w_unsafe = ((LA != L_RED) && (LB != L_RED))
                  || !is_legal_light(LA) || !is_legal_light(LB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflict <= 1'b0;
    end else if (w_unsafe) begin
      r_conflict <= 1'b1;
    end
  end

  assign conflict = r_conflict;

endmodule

// File: tb/tb_traffic_sensor_model.sv
// ---------------------------------------------------------------------------
// tb_traffic_sensor_model
// Scoreboard bench: the driver steps a behavioural street model once per
// clock edge and queues the expected outputs; a monitor on the falling edge
// pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_traffic_sensor_model;

  localparam int QW   = 4;
  localparam int DT   = 6;
  localparam int HOLD = 2;
  localparam int QMAX = (1 << QW) - 1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic          clk = 1'b0;
  logic          reset;
  logic          arrA, arrB;
  logic [2:0]    LA, LB;
  logic          Ta, Tb;
  logic [QW-1:0] qA, qB;
  logic          departA, departB, ovfA, ovfB, conflict;

  typedef struct packed {
    logic          ta;
    logic          tb;
    logic [QW-1:0] qa;
    logic [QW-1:0] qb;
    logic          depA;
    logic          depB;
    logic          ovA;
    logic          ovB;
    logic          conf;
  } obs_t;

  obs_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Behavioural model state: cars waiting, green cycles spent on the car at
  // the head of the queue, consecutive edges seen with cars waiting.
  int mCars[2];
  int mGreenSpent[2];
  int mWaitEdges[2];
  bit mOvf[2];
  bit mDep[2];
  bit mConf;

  traffic_sensor_model #(.QW(QW), .DRAIN_TICKS(DT), .HOLD(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .arrA     (arrA),
    .arrB     (arrB),
    .LA       (LA),
    .LB       (LB),
    .Ta       (Ta),
    .Tb       (Tb),
    .qA       (qA),
    .qB       (qB),
    .departA  (departA),
    .departB  (departB),
    .ovfA     (ovfA),
    .ovfB     (ovfB),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  function automatic obs_t dutObs();
    return {Ta, Tb, qA, qB, departA, departB, ovfA, ovfB, conflict};
  endfunction

  function automatic obs_t modelObs();
    obs_t o;
    o.ta   = (mWaitEdges[0] >= HOLD);
    o.tb   = (mWaitEdges[1] >= HOLD);
    o.qa   = QW'(mCars[0]);
    o.qb   = QW'(mCars[1]);
    o.depA = mDep[0];
    o.depB = mDep[1];
    o.ovA  = mOvf[0];
    o.ovB  = mOvf[1];
    o.conf = mConf;
    return o;
  endfunction

  function automatic bit legalCode(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      mCars[s] = 0; mGreenSpent[s] = 0; mWaitEdges[s] = 0;
      mOvf[s] = 0; mDep[s] = 0;
    end
    mConf = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    bit         a[2];
    logic [2:0] l[2];
    bit         leave;
    int         waiting;
    a[0] = arrA; a[1] = arrB;
    l[0] = LA;   l[1] = LB;
    if (!(LA == RED || LB == RED) || !legalCode(LA) || !legalCode(LB))
      mConf = 1;
    for (int s = 0; s < 2; s++) begin
      waiting = mCars[s];
      leave = 0;
      if (l[s] == GRN && waiting > 0) begin
        mGreenSpent[s]++;
        if (mGreenSpent[s] == DT) begin
          leave = 1;
          mGreenSpent[s] = 0;
        end
      end else begin
        mGreenSpent[s] = 0;
      end
      mDep[s] = leave;
      mWaitEdges[s] = (waiting > 0) ? ((mWaitEdges[s] + 1 > HOLD) ? HOLD : mWaitEdges[s] + 1) : 0;
      if (a[s] && !leave) begin
        if (waiting == QMAX) mOvf[s] = 1;
        else mCars[s] = waiting + 1;
      end else if (!a[s] && leave) begin
        mCars[s] = waiting - 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got %p expected %p", name, $time, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One cycle: let the edge happen, record what the DUT must now show, then
  // present the next inputs.
  task automatic applyStimulus(input logic a, input logic b,
                               input logic [2:0] la, input logic [2:0] lb);
    @(posedge clk);
    #1;
    if (reset) begin
      modelStep();
      expQ.push_back(modelObs());
    end
    arrA = a; arrB = b; LA = la; LB = lb;
  endtask

  task automatic idle(input int n, input logic [2:0] la, input logic [2:0] lb);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, la, lb);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    arrA = 1'b0; arrB = 1'b0; LA = RED; LB = RED;
    #1;
    checkOutput("async reset", dutObs(), '0);
    expQ.delete();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: the DUT presents a fresh output set every cycle out of reset.
  always @(negedge clk) begin
    obs_t e;
    if (reset && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("cycle", dutObs(), e);
    end
  end

  initial begin
    logic [2:0] ph[4][2];
    int phase;
    reset = 1'b0;
    arrA = 1'b0; arrB = 1'b0; LA = RED; LB = RED;
    modelReset();
    #12;
    checkOutput("initial reset", dutObs(), '0);
    doReset();

    // Presence build-up on A while B shows green to an empty street.
    idle(2, RED, GRN);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, RED, GRN);
      applyStimulus(1'b0, 1'b0, RED, GRN);
    end
    idle(3, RED, GRN);

    // Drain A completely.
    idle(25, GRN, RED);
    checkValue("drained qA", qA, 0);

    // Freeze: three cars, one departure, then yellow holds the queue.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, RED, GRN);
    idle(6, GRN, RED);
    idle(4, YEL, RED);
    checkValue("freeze qA", qA, 2);
    idle(15, GRN, RED);

    // Arrival coincident with a departure edge.
    applyStimulus(1'b1, 1'b0, RED, GRN);
    applyStimulus(1'b1, 1'b0, RED, GRN);
    idle(5, GRN, RED);
    applyStimulus(1'b1, 1'b0, GRN, RED);
    applyStimulus(1'b0, 1'b0, GRN, RED);
    checkValue("simul qA", qA, 2);
    checkValue("simul departA", departA, 1);
    checkValue("simul ovfA", ovfA, 0);
    idle(15, GRN, RED);

    // Overflow: sixteen arrivals on red, then a long drain.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, RED, GRN);
    applyStimulus(1'b0, 1'b0, RED, GRN);
    checkValue("ovf qA", qA, QMAX);
    checkValue("ovf ovfA", ovfA, 1);
    idle(100, GRN, RED);
    checkValue("ovf sticky", ovfA, 1);
    checkValue("ovf drained qA", qA, 0);

    // Mid-operation reset with five cars on A.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, RED, GRN);
    applyStimulus(1'b0, 1'b0, RED, GRN);
    checkValue("pre-reset qA", qA, 5);
    doReset();

    // Conflicts: green with yellow, then an illegal code.
    applyStimulus(1'b0, 1'b0, GRN, YEL);
    idle(2, RED, GRN);
    checkValue("conflict GY", conflict, 1);
    doReset();
    applyStimulus(1'b0, 1'b0, 3'b011, RED);
    idle(2, RED, GRN);
    checkValue("conflict illegal", conflict, 1);
    doReset();

    // Legal rotation keeps the monitor quiet.
    idle(3, GRN, RED); idle(3, YEL, RED); idle(3, RED, GRN); idle(3, RED, YEL);
    checkValue("legal rotation", conflict, 0);

    // Random traffic under a legal light rotation.
    ph[0][0] = GRN; ph[0][1] = RED;
    ph[1][0] = YEL; ph[1][1] = RED;
    ph[2][0] = RED; ph[2][1] = GRN;
    ph[3][0] = RED; ph[3][1] = YEL;
    phase = 0;
    for (int n = 0; n < 40; n++) begin
      int len;
      len = (phase % 2 == 0) ? int'($urandom_range(3, 20)) : 2;
      for (int i = 0; i < len; i++)
        applyStimulus(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
                      ph[phase][0], ph[phase][1]);
      phase = (phase + 1) % 4;
    end
    checkValue("random legal conflict", conflict, 0);

    // Fully random light codes, including illegal ones.
    for (int i = 0; i < 80; i++)
      applyStimulus(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    @(negedge clk);
    #1;
    checkValue("scoreboard drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
